mem_stage: RTL and testbench

- Memory stage of the 5-stage RISC-V pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its MEM_* outputs.
- Performs 64-bit ld/sd accesses to data memory over a variable-latency req/ack handshake.
- Asserts a stall toward the hazard unit while an access is outstanding.
- Registers results into the MEM/WB boundary as WB_* outputs.

---
 rtl/mem_stage.sv | 155 +++++++++++++++
 tb/tb_mem_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage RISC-V pipeline.
// Issues 64-bit ld/sd accesses over a variable-latency req/ack handshake.
// While an access is outstanding it stalls the upstream stages.
// Each instruction retires into the MEM/WB boundary (WB_* outputs).
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that are not acked
// within TIMEOUT_CYCLES ACCESS cycles. An abort sets the sticky mem_err flag.
module mem_stage #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] MEM_ALUResult,
  input  logic [XLEN-1:0] MEM_WriteData,
  input  logic [4:0]      MEM_rd,
  input  logic            MEM_RegWrite,
  input  logic            MEM_MemToReg,
  input  logic            MEM_MemWrite,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic [XLEN-1:0] WB_ALUResult,
  output logic [XLEN-1:0] WB_ReadData,
  output logic [4:0]      WB_rd,
  output logic            WB_RegWrite,
  output logic            WB_MemToReg,
  output logic            mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_next;

  logic memop;
  logic is_load;
  logic is_store;
  logic ack_ok;
  logic timeout_hit;

  // An abort after zero cycles is meaningless, so reject it when the design is elaborated.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
  end

  // Decoding: if both MemToReg and MemWrite are set (illegal), the instruction is a store.
  assign memop    = MEM_MemToReg | MEM_MemWrite;
  assign is_store = MEM_MemWrite;
  assign is_load  = MEM_MemToReg & ~MEM_MemWrite;

  // An ack counts only while a request is outstanding.
  assign ack_ok   = (state == ACCESS) && dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // The abort fires on the last allowed ACCESS cycle, and only if no ack arrives in it.
  assign timeout_hit = (state == ACCESS) && !dmem_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count the unacked ACCESS cycles. The count is held at zero while IDLE.
  // That way it starts cleared on every entry to ACCESS.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) wait_cnt <= '0;
    else if (!dmem_ack)       wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Sticky error flag. It is set by an abort and cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)              mem_err <= 1'b0;
    else if (timeout_hit) mem_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  // Upstream is released on the completing edge, or on the abort edge.
  assign mem_stall = memop & ~ack_ok & ~timeout_hit;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking (<=). Then every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: enter ACCESS on a memop, leave it on an ack or an abort.
  always_comb begin
    // NOTE: assign the default first, so no path through the block leaves a latch behind.
    state_next = state;
    unique case (state)
      IDLE:    if (memop)                   state_next = ACCESS;
      ACCESS:  if (dmem_ack || timeout_hit) state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // Request registers and the MEM/WB boundary.
  // WB_ReadData changes only when a load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      WB_ALUResult <= '0;
      WB_ReadData  <= '0;
      WB_rd        <= '0;
      WB_RegWrite  <= 1'b0;
      WB_MemToReg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memop) begin
            // Launch the request. WB receives a bubble while the access is in flight.
            dmem_req    <= 1'b1;
            dmem_we     <= is_store;
            dmem_addr   <= MEM_ALUResult;
            dmem_wdata  <= MEM_WriteData;
            WB_RegWrite <= 1'b0;
            WB_MemToReg <= 1'b0;
          end else begin
            WB_ALUResult <= MEM_ALUResult;
            WB_rd        <= MEM_rd;
            WB_RegWrite  <= MEM_RegWrite;
            WB_MemToReg  <= is_load;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            // The ack takes priority over a timeout in the same cycle.
            dmem_req     <= 1'b0;
            WB_ALUResult <= MEM_ALUResult;
            WB_rd        <= MEM_rd;
            WB_RegWrite  <= MEM_RegWrite;
            WB_MemToReg  <= is_load;
            if (is_load) WB_ReadData <= dmem_rdata;
          end else begin
            WB_RegWrite <= 1'b0;
            WB_MemToReg <= 1'b0;
            if (timeout_hit) dmem_req <= 1'b0;
          end
        end
        default: dmem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Directed vectors come from a table. Random ALU/ld/sd streams with random ack latency
// are checked against a transaction-level model, which keeps its own view of data memory.
// The hand-written sequences cover reset and, when MEM_TIMEOUT_EN is defined, timeout.
module tb_mem_stage;

  localparam int XLEN = 64;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] MEM_ALUResult, MEM_WriteData;
  logic [4:0]      MEM_rd;
  logic            MEM_RegWrite, MEM_MemToReg, MEM_MemWrite;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic            mem_stall;
  logic [XLEN-1:0] WB_ALUResult, WB_ReadData;
  logic [4:0]      WB_rd;
  logic            WB_RegWrite, WB_MemToReg, mem_err;

  mem_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .MEM_ALUResult(MEM_ALUResult), .MEM_WriteData(MEM_WriteData), .MEM_rd(MEM_rd),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg), .MEM_MemWrite(MEM_MemWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .WB_ALUResult(WB_ALUResult), .WB_ReadData(WB_ReadData), .WB_rd(WB_rd),
    .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected MEM/WB contents, updated as each instruction retires.
  logic [63:0] e_alu, e_rdata;
  logic [4:0]  e_rd;
  logic        e_rw, e_m2r;

  // model_mem is updated from the instruction stream.
  // resp_mem is the responder's storage and is written only through the DUT's dmem port.
  logic [63:0] model_mem [logic [63:0]];
  logic [63:0] resp_mem  [logic [63:0]];

  typedef struct {
    logic        ld, sd;
    logic [63:0] alu, wd;
    logic [4:0]  rd;
    logic        rw;
    int          waits;
    logic [63:0] x_rdata;
    logic        x_rw, x_m2r;
    logic [4:0]  x_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag);
    check({tag, ".wb_alu"},   WB_ALUResult, e_alu);
    check({tag, ".wb_rdata"}, WB_ReadData,  e_rdata);
    check({tag, ".wb_rd"},    {59'd0, WB_rd}, {59'd0, e_rd});
    check({tag, ".wb_rw"},    WB_RegWrite,  e_rw);
    check({tag, ".wb_m2r"},   WB_MemToReg,  e_m2r);
  endtask

  function automatic logic [63:0] model_read(input logic [63:0] a);
    return model_mem.exists(a) ? model_mem[a] : 64'd0;
  endfunction

  // Run one instruction through the stage. The caller has just passed a posedge (+1).
  task automatic exec(input logic ld, input logic sd, input logic [63:0] alu,
                      input logic [63:0] wd, input logic [4:0] rd, input logic rw,
                      input int waits);
    logic [63:0] rdv;
    MEM_ALUResult = alu; MEM_WriteData = wd; MEM_rd = rd;
    MEM_RegWrite = rw; MEM_MemToReg = ld; MEM_MemWrite = sd;
    dmem_ack = 1'b0;
    #1;
    if (!(ld | sd)) begin
      check("alu.stall", mem_stall, 1'b0);
      tick();
      e_alu = alu; e_rd = rd; e_rw = rw; e_m2r = 1'b0;
      check_wb("alu");
    end else begin
      check("idle.req", dmem_req, 1'b0);
      check("idle.stall", mem_stall, 1'b1);
      tick();
      e_rw = 1'b0; e_m2r = 1'b0;
      for (int c = 0; c <= waits; c++) begin
        check("acc.req",   dmem_req, 1'b1);
        check("acc.addr",  dmem_addr, alu);
        check("acc.we",    dmem_we, sd);
        if (sd) check("acc.wdata", dmem_wdata, wd);
        check("acc.bubble_rw", WB_RegWrite, 1'b0);
        check("acc.hold_rdata", WB_ReadData, e_rdata);
        if (c < waits) begin
          check("acc.stall", mem_stall, 1'b1);
          dmem_rdata = {$urandom, $urandom};
          tick();
        end
      end
      rdv = resp_mem.exists(dmem_addr) ? resp_mem[dmem_addr] : 64'd0;
      dmem_rdata = rdv;
      dmem_ack   = 1'b1;
      #1;
      check("ack.stall", mem_stall, 1'b0);
      if (dmem_we) resp_mem[dmem_addr] = dmem_wdata;
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = {$urandom, $urandom};
      e_alu = alu; e_rd = rd; e_rw = rw; e_m2r = ld & ~sd;
      if (sd) model_mem[alu] = wd;
      else    e_rdata = model_read(alu);
      check_wb("mem");
    end
  endtask

  task automatic clear_model();
    e_alu = '0; e_rdata = '0; e_rd = '0; e_rw = 1'b0; e_m2r = 1'b0;
  endtask

  initial begin
    logic [63:0] a, w;
    int k;

    // Both memories start with identical contents.
    model_mem[64'h8]   = 64'h1111_0008; resp_mem[64'h8]   = 64'h1111_0008;
    model_mem[64'h10]  = 64'h2222_0010; resp_mem[64'h10]  = 64'h2222_0010;
    model_mem[64'h100] = 64'hDEADBEEF;  resp_mem[64'h100] = 64'hDEADBEEF;

    //                ld    sd    alu      wd       rd  rw  w  x_rdata         x_rw  x_m2r x_rd
    vecs[0] = '{1'b0, 1'b0, 64'h2A,  64'h0,    5'd5, 1'b1, 0, 64'h0,          1'b1, 1'b0, 5'd5};
    vecs[1] = '{1'b1, 1'b0, 64'h100, 64'h0,    5'd7, 1'b1, 0, 64'hDEADBEEF,   1'b1, 1'b1, 5'd7};
    vecs[2] = '{1'b0, 1'b1, 64'h200, 64'h1234, 5'd0, 1'b0, 3, 64'hDEADBEEF,   1'b0, 1'b0, 5'd0};
    vecs[3] = '{1'b1, 1'b0, 64'h8,   64'h0,    5'd9, 1'b1, 0, 64'h1111_0008,  1'b1, 1'b1, 5'd9};
    vecs[4] = '{1'b1, 1'b0, 64'h10,  64'h0,   5'd10, 1'b1, 0, 64'h2222_0010,  1'b1, 1'b1, 5'd10};
    vecs[5] = '{1'b1, 1'b0, 64'h200, 64'h0,   5'd11, 1'b1, 1, 64'h1234,       1'b1, 1'b1, 5'd11};

    // Reset for two cycles while the inputs are arbitrary.
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      MEM_ALUResult = {$urandom, $urandom}; MEM_WriteData = {$urandom, $urandom};
      MEM_rd = 5'($urandom); MEM_RegWrite = 1'($urandom);
      MEM_MemToReg = 1'($urandom); MEM_MemWrite = 1'($urandom);
      dmem_ack = 1'($urandom);
      tick();
      check("rst.req", dmem_req, 1'b0);
      check("rst.we", dmem_we, 1'b0);
      check("rst.addr", dmem_addr, 64'd0);
      check("rst.wdata", dmem_wdata, 64'd0);
      check("rst.err", mem_err, 1'b0);
      clear_model();
      check_wb("rst");
      check("rst.stall", mem_stall, MEM_MemToReg | MEM_MemWrite);
    end
    rst = 1'b0;
    dmem_ack = 1'b0;

    // Directed vectors.
    foreach (vecs[i]) begin
      exec(vecs[i].ld, vecs[i].sd, vecs[i].alu, vecs[i].wd, vecs[i].rd, vecs[i].rw, vecs[i].waits);
      check("vec.rdata", WB_ReadData, vecs[i].x_rdata);
      check("vec.rw",    WB_RegWrite, vecs[i].x_rw);
      check("vec.m2r",   WB_MemToReg, vecs[i].x_m2r);
      check("vec.rd",    {59'd0, WB_rd}, {59'd0, vecs[i].x_rd});
    end

    // Random stream: ALU ops, loads, stores and the illegal both-set case, with random ack latency.
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      a = 64'($urandom_range(0, 7)) << 3;
      w = {$urandom, $urandom};
      if (k <= 3)      exec(1'b0, 1'b0, w, {$urandom, $urandom}, 5'($urandom), 1'($urandom), 0);
      else if (k <= 6) exec(1'b1, 1'b0, a, w, 5'($urandom), 1'b1, $urandom_range(0, 3));
      else if (k <= 8) exec(1'b0, 1'b1, a, w, 5'($urandom), 1'b0, $urandom_range(0, 3));
      else             exec(1'b1, 1'b1, a, w, 5'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    // Assert reset during the second ACCESS cycle. A late ack afterwards must be ignored.
    MEM_ALUResult = 64'h8; MEM_WriteData = '0; MEM_rd = 5'd3;
    MEM_RegWrite = 1'b1; MEM_MemToReg = 1'b1; MEM_MemWrite = 1'b0;
    tick();
    check("mid.req", dmem_req, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    check("mid.req_rst", dmem_req, 1'b0);
    check("mid.addr_rst", dmem_addr, 64'd0);
    check_wb("mid");
    MEM_ALUResult = '0; MEM_rd = '0; MEM_RegWrite = 1'b0; MEM_MemToReg = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 64'hBAD;
    tick();
    dmem_ack = 1'b0;
    check("late_ack.req", dmem_req, 1'b0);
    check_wb("late_ack");
    exec(1'b0, 1'b0, 64'h77, 64'h0, 5'd2, 1'b1, 0);

`ifdef MEM_TIMEOUT_EN
    // A load that is never acked is aborted after TO ACCESS cycles.
    MEM_ALUResult = 64'h10; MEM_rd = 5'd4; MEM_RegWrite = 1'b1;
    MEM_MemToReg = 1'b1; MEM_MemWrite = 1'b0; dmem_ack = 1'b0;
    tick();
    for (int c = 0; c < TO; c++) begin
      check("to.req", dmem_req, 1'b1);
      check("to.stall", mem_stall, (c < TO - 1) ? 1'b1 : 1'b0);
      check("to.err_pre", mem_err, 1'b0);
      tick();
    end
    check("to.req_drop", dmem_req, 1'b0);
    check("to.err", mem_err, 1'b1);
    check("to.bubble_rw", WB_RegWrite, 1'b0);
    check("to.bubble_m2r", WB_MemToReg, 1'b0);
    exec(1'b0, 1'b0, 64'h99, 64'h0, 5'd6, 1'b1, 0);
    check("to.err_sticky", mem_err, 1'b1);
`else
    check("err.tied", mem_err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
